nco_sweep_ctrl: RTL and testbench



---
 rtl/nco_ctrl_pkg.sv | 35 +++
 rtl/nco_dwell_timer.sv | 38 +++
 rtl/nco_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_ctrl_pkg.sv
// Shared types and constants for the NCO frequency/phase sweep sequencer.
//   - default widths for control words, step index and dwell counter
//   - sequencer state enum and sweep descriptor struct
//   - last_idx(): index of the final FCW of a sweep (a count of 0 acts as 1)
package nco_ctrl_pkg;

    localparam int FCW_W_DFLT   = 28;
    localparam int STEP_W_DFLT  = 16;
    localparam int DWELL_W_DFLT = 24;

    // Quarter of the full 2^28 phase circle: 90 degrees on the phase input,
    // fs/4 on the frequency input.
    localparam logic [FCW_W_DFLT-1:0] FCW_QUARTER_CLK = 28'd67108864;
    localparam logic [FCW_W_DFLT-1:0] PHASE_90        = 28'd67108864;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [FCW_W_DFLT-1:0]   start_fcw;
        logic [FCW_W_DFLT-1:0]   step_fcw;
        logic [STEP_W_DFLT-1:0]  num_steps;
        logic [DWELL_W_DFLT-1:0] dwell;
        logic [FCW_W_DFLT-1:0]   phase;
        logic                    rpt;
    } sweep_desc_t;

    function automatic logic [STEP_W_DFLT-1:0] last_idx(input logic [STEP_W_DFLT-1:0] num);
        return (num == '0) ? '0 : num - 1'b1;
    endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Per-step dwell timer: a down-counter loaded with max(dwell,1)-1.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : (re)load the counter from dwell_i
//   dwell_i      : cycles each FCW is held (0 behaves as 1)
//   expired_o    : counter is at zero, i.e. current FCW is in its last cycle
module nco_dwell_timer #(
    parameter int DWELL_W = 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               expired_o
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (dwell_i == '0) ? '0 : dwell_i - 1'b1;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency/phase sweep sequencer driving the NCO control words.
//   cfg_*_i      : sweep descriptor, accepted on cfg_valid_i && cfg_ready_o
//   start_i      : start a sweep (IDLE/HOLD only, needs a loaded descriptor)
//   abort_i      : return to IDLE with zeroed outputs; wins over start/cfg
//   fre_chtr_o   : registered frequency control word
//   pha_chtr_o   : registered phase control word
//   busy_o       : sweep running
//   step_strobe_o: first cycle of each newly presented FCW
//   step_idx_o   : index of the FCW being presented
//   done_o       : one-cycle pulse when a non-repeating sweep finishes
//
// state | meaning
// IDLE  | no sweep, control words zero
// RUN   | sweeping, FCW advances on dwell expiry
// HOLD  | sweep finished, last FCW/phase held
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int FCW_W   = FCW_W_DFLT,
    parameter int STEP_W  = STEP_W_DFLT,
    parameter int DWELL_W = DWELL_W_DFLT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [FCW_W-1:0]   cfg_start_fcw_i,
    input  logic [FCW_W-1:0]   cfg_step_fcw_i,
    input  logic [STEP_W-1:0]  cfg_num_steps_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic [FCW_W-1:0]   cfg_phase_i,
    input  logic               cfg_repeat_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic [FCW_W-1:0]   fre_chtr_o,
    output logic [FCW_W-1:0]   pha_chtr_o,
    output logic               busy_o,
    output logic               step_strobe_o,
    output logic [STEP_W-1:0]  step_idx_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    sweep_desc_t        desc_q, desc_d;
    logic               loaded_q, loaded_d;
    logic [FCW_W-1:0]   fre_q, fre_d;
    logic [FCW_W-1:0]   pha_q, pha_d;
    logic [STEP_W-1:0]  idx_q, idx_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;

    logic               cfg_fire;
    sweep_desc_t        cfg_in;
    sweep_desc_t        desc_use;
    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_dwell;
    logic               tmr_expired;

    // Abort blocks the handshake so an aborting cycle never loads a descriptor.
    assign cfg_ready_o = (state_q != RUN) && !abort_i;
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;
    assign cfg_in      = '{start_fcw: cfg_start_fcw_i, step_fcw: cfg_step_fcw_i,
                           num_steps: cfg_num_steps_i, dwell: cfg_dwell_i,
                           phase: cfg_phase_i, rpt: cfg_repeat_i};
    // A descriptor arriving with start is used directly for the first FCW.
    assign desc_use    = cfg_fire ? cfg_in : desc_q;

    always_comb begin
        state_d   = state_q;
        desc_d    = desc_q;
        loaded_d  = loaded_q;
        fre_d     = fre_q;
        pha_d     = pha_q;
        idx_d     = idx_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_dwell = desc_q.dwell;

        if (abort_i) begin
            state_d = IDLE;
            fre_d   = '0;
            pha_d   = '0;
            idx_d   = '0;
        end else begin
            if (cfg_fire) begin
                desc_d   = cfg_in;
                loaded_d = 1'b1;
            end
            case (state_q)
                IDLE, HOLD: begin
                    if (start_i && (loaded_q || cfg_fire)) begin
                        state_d   = RUN;
                        fre_d     = desc_use.start_fcw;
                        pha_d     = desc_use.phase;
                        idx_d     = '0;
                        strobe_d  = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_dwell = desc_use.dwell;
                    end
                end
                RUN: begin
                    if (tmr_expired) begin
                        if (idx_q != last_idx(desc_q.num_steps)) begin
                            fre_d    = fre_q + desc_q.step_fcw;
                            idx_d    = idx_q + 1'b1;
                            strobe_d = 1'b1;
                            tmr_load = 1'b1;
                        end else if (desc_q.rpt) begin
                            fre_d    = desc_q.start_fcw;
                            idx_d    = '0;
                            strobe_d = 1'b1;
                            tmr_load = 1'b1;
                        end else begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            desc_q   <= '0;
            loaded_q <= 1'b0;
            fre_q    <= '0;
            pha_q    <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            desc_q   <= desc_d;
            loaded_q <= loaded_d;
            fre_q    <= fre_d;
            pha_q    <= pha_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    nco_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (tmr_load),
        .dwell_i   (tmr_dwell),
        .expired_o (tmr_expired)
    );

    assign fre_chtr_o    = fre_q;
    assign pha_chtr_o    = pha_q;
    assign busy_o        = (state_q == RUN);
    assign step_strobe_o = strobe_q;
    assign step_idx_o    = idx_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
module tb_nco_sweep_ctrl;

    localparam logic [27:0] PH90 = 28'd67108864;

    logic        clk = 1'b0;
    logic        rst, cfg_valid, cfg_ready, cfg_repeat, start, abort;
    logic [27:0] cfg_start_fcw, cfg_step_fcw, cfg_phase;
    logic [15:0] cfg_num_steps;
    logic [23:0] cfg_dwell;
    logic [27:0] fre_chtr, pha_chtr;
    logic        busy, step_strobe, done;
    logic [15:0] step_idx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nco_sweep_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_start_fcw_i (cfg_start_fcw),
        .cfg_step_fcw_i  (cfg_step_fcw),
        .cfg_num_steps_i (cfg_num_steps),
        .cfg_dwell_i     (cfg_dwell),
        .cfg_phase_i     (cfg_phase),
        .cfg_repeat_i    (cfg_repeat),
        .start_i         (start),
        .abort_i         (abort),
        .fre_chtr_o      (fre_chtr),
        .pha_chtr_o      (pha_chtr),
        .busy_o          (busy),
        .step_strobe_o   (step_strobe),
        .step_idx_o      (step_idx),
        .done_o          (done)
    );

    // Reference: the n-th FCW of a sweep is start + n*step modulo 2^28.
    function automatic logic [27:0] m_fcw(input logic [27:0] s, input logic [27:0] st, input int n);
        logic [63:0] acc;
        acc = 64'(s) + 64'(st) * 64'(n);
        return acc[27:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [27:0] s, input logic [27:0] st, input logic [15:0] n,
                           input logic [23:0] d, input logic [27:0] ph, input logic r);
        cfg_start_fcw = s; cfg_step_fcw = st; cfg_num_steps = n;
        cfg_dwell = d; cfg_phase = ph; cfg_repeat = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_tests++;
        if ({fre_chtr, pha_chtr, step_idx, busy, step_strobe, done, cfg_ready} !==
            {28'd0, 28'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state fre=%0d pha=%0d idx=%0d busy=%b stb=%b done=%b rdy=%b, want zeros and rdy=1",
                     fre_chtr, pha_chtr, step_idx, busy, step_strobe, done, cfg_ready);
        end
        start = 1'b1; tick(); start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || fre_chtr !== 28'd0 || step_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_unloaded busy=%b fre=%0d stb=%b, want 0/0/0", busy, fre_chtr, step_strobe);
        end
    endtask

    // Full non-repeating sweep checked cycle by cycle against the reference.
    task automatic test_sweep(input string nm, input logic [27:0] s, input logic [27:0] st,
                              input logic [15:0] n, input logic [23:0] d, input logic [27:0] ph,
                              input bit same_cycle);
        int ne, de, tot;
        ne  = (n == 0) ? 1 : int'(n);
        de  = (d == 0) ? 1 : int'(d);
        tot = ne * de;
        set_cfg(s, st, n, d, ph, 1'b0);
        cfg_valid = 1'b1;
        if (!same_cycle) begin
            tick();
            cfg_valid = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0; cfg_valid = 1'b0;
        for (int k = 0; k < tot; k++) begin
            n_tests++;
            if ({fre_chtr, pha_chtr, step_idx, step_strobe, busy, done, cfg_ready} !==
                {m_fcw(s, st, k / de), ph, 16'(k / de), (k % de) == 0, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got fre=%h pha=%h idx=%0d stb=%b busy=%b done=%b rdy=%b exp fre=%h pha=%h idx=%0d stb=%b",
                         nm, k, fre_chtr, pha_chtr, step_idx, step_strobe, busy, done, cfg_ready,
                         m_fcw(s, st, k / de), ph, k / de, (k % de) == 0);
            end
            tick();
        end
        n_tests++;
        if ({done, busy, step_strobe, fre_chtr, pha_chtr, step_idx} !==
            {1'b1, 1'b0, 1'b0, m_fcw(s, st, ne - 1), ph, 16'(ne - 1)}) begin
            n_fail++;
            $display("FAIL %s_done got done=%b busy=%b stb=%b fre=%h idx=%0d exp 1/0/0 fre=%h idx=%0d",
                     nm, done, busy, step_strobe, fre_chtr, step_idx, m_fcw(s, st, ne - 1), ne - 1);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || fre_chtr !== m_fcw(s, st, ne - 1) || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_hold got done=%b fre=%h rdy=%b exp 0 fre=%h rdy=1",
                     nm, done, fre_chtr, cfg_ready, m_fcw(s, st, ne - 1));
        end
    endtask

    task automatic test_basic();
        test_sweep("basic", 28'd1000, 28'd500, 16'd4, 24'd3, PH90, 1'b0);
    endtask

    task automatic test_wrap_neg();
        test_sweep("wrap", 28'hFFFFF00, 28'h0000200, 16'd2, 24'd2, 28'd0, 1'b0);
        test_sweep("negstep", 28'd1000, 28'hFFFFF9C, 16'd3, 24'd2, 28'd123, 1'b0);
    endtask

    task automatic test_degenerate();
        test_sweep("degen", 28'd1234, 28'd7, 16'd0, 24'd0, PH90, 1'b0);
    endtask

    task automatic test_abort();
        int cyc;
        set_cfg(28'd1000, 28'd500, 16'd4, 24'd3, PH90, 1'b0);
        cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        n_tests++;
        if (step_idx !== 16'd2 || fre_chtr !== 28'd2000) begin
            n_fail++;
            $display("FAIL abort_pre idx=%0d fre=%0d, want 2/2000", step_idx, fre_chtr);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        n_tests++;
        if ({fre_chtr, pha_chtr, step_idx, busy, done, step_strobe} !== {28'd0, 28'd0, 16'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_state fre=%0d pha=%0d idx=%0d busy=%b done=%b stb=%b, want zeros",
                     fre_chtr, pha_chtr, step_idx, busy, done, step_strobe);
        end
        tick(); tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet done=%b busy=%b, want 0/0", done, busy);
        end
        start = 1'b1; tick(); start = 1'b0;
        n_tests++;
        if (fre_chtr !== 28'd1000 || step_strobe !== 1'b1 || busy !== 1'b1 || pha_chtr !== PH90) begin
            n_fail++;
            $display("FAIL abort_replay fre=%0d stb=%b busy=%b pha=%0d, want 1000/1/1/%0d",
                     fre_chtr, step_strobe, busy, pha_chtr, PH90);
        end
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_tests++;
        if (cyc != 12 || fre_chtr !== 28'd2500) begin
            n_fail++;
            $display("FAIL abort_replay_done cycles=%0d fre=%0d, want 12/2500 (-1 means timeout)", cyc, fre_chtr);
        end
        tick();
    endtask

    task automatic test_repeat_handshake();
        set_cfg(28'd10, 28'd5, 16'd2, 24'd1, PH90, 1'b1);
        cfg_valid = 1'b1; tick();
        start = 1'b1; tick(); start = 1'b0;
        // Competing descriptor held valid throughout the run must be refused.
        set_cfg(28'd777, 28'd1, 16'd7, 24'd9, 28'd5, 1'b0);
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if ({fre_chtr, step_strobe, done, busy, cfg_ready, pha_chtr} !==
                {m_fcw(28'd10, 28'd5, k % 2), 1'b1, 1'b0, 1'b1, 1'b0, PH90}) begin
                n_fail++;
                $display("FAIL repeat cyc=%0d got fre=%0d stb=%b done=%b busy=%b rdy=%b pha=%0d exp fre=%0d",
                         k, fre_chtr, step_strobe, done, busy, cfg_ready, pha_chtr, m_fcw(28'd10, 28'd5, k % 2));
            end
            start = (k == 4);
            tick();
        end
        start = 1'b0; cfg_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || fre_chtr !== 28'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_abort busy=%b fre=%0d done=%b, want 0/0/0", busy, fre_chtr, done);
        end
        start = 1'b1; tick(); start = 1'b0;
        n_tests++;
        if (fre_chtr !== 28'd10 || pha_chtr !== PH90) begin
            n_fail++;
            $display("FAIL repeat_kept_desc fre=%0d pha=%0d, want 10/%0d", fre_chtr, pha_chtr, PH90);
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_random();
        logic [27:0] s, st, ph;
        for (int i = 0; i < 8; i++) begin
            s  = 28'($urandom);
            st = 28'($urandom);
            ph = 28'($urandom);
            test_sweep("random", s, st, 16'($urandom_range(0, 5)), 24'($urandom_range(0, 4)), ph,
                       bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(28'd1000, 28'd500, 16'd4, 24'd3, PH90, 1'b0);
        cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++;
        if ({fre_chtr, pha_chtr, step_idx, busy, done, step_strobe, cfg_ready} !==
            {28'd0, 28'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid fre=%0d pha=%0d idx=%0d busy=%b done=%b stb=%b rdy=%b, want zeros rdy=1",
                     fre_chtr, pha_chtr, step_idx, busy, done, step_strobe, cfg_ready);
        end
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || fre_chtr !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_mid_start busy=%b fre=%0d, want 0/0 (descriptor cleared)", busy, fre_chtr);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        set_cfg(28'd0, 28'd0, 16'd0, 24'd0, 28'd0, 1'b0);
        test_reset();
        test_basic();
        test_wrap_neg();
        test_degenerate();
        test_abort();
        test_repeat_handshake();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
